mem_access_unit: RTL and testbench

- Downstream of the load/store queue; consumes the single `execute_pkt` the LSQ issues and performs the data-memory access.
- Drives a valid/ready data-memory port.
- Formats load data (byte/half/word with sign/zero extension) and generates store byte enables.
- Returns a `writeback_packet_t` on a CDB port; also accepts store-to-load forwarded results from the LSQ and writes them back without touching memory.

---
 rtl/uarch_pkg.sv | 63 ++++++
 rtl/mem_lane_fmt.sv | 61 ++++++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the memory access unit.
// Provides the LSQ issue packet (instruction_t), the CDB write-back packet
// (writeback_packet_t), the access-unit FSM state enum, funct3 load/store
// encodings and small helpers for access size and alignment.
package uarch_pkg;

  localparam int unsigned MAU_XLEN = 32;
  localparam int unsigned TAG_W    = 6;

  // funct3 encodings; stores reuse the low two bits of the load encoding
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic                is_valid;
    logic                is_store;
    logic [2:0]          funct3;
    logic [MAU_XLEN-1:0] addr;
    logic [MAU_XLEN-1:0] store_data;
    logic [TAG_W-1:0]    dest_tag;
  } instruction_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    dest_tag;
    logic [MAU_XLEN-1:0] data;
    logic                exception;
  } writeback_packet_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } mau_state_e;

  // Unknown funct3 values are treated as word accesses.
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    case (f3_size(f3))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter.
// Ports:
//   i_is_store   - 1 selects store lane generation, 0 gives be/wdata = 0
//   i_funct3     - access size / signedness
//   i_addr_lo    - byte offset within the word
//   i_store_data - register value to store
//   i_rdata      - raw memory word for loads
//   o_be         - store byte enables
//   o_wdata      - store data replicated across lanes
//   o_load_data  - load value extracted and sign/zero extended
module mem_lane_fmt
  import uarch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_load_data
);

  logic [XLEN-1:0] w_shifted;

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    if (i_is_store) begin
      case (f3_size(i_funct3))
        SZ_BYTE: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {(XLEN/8){i_store_data[7:0]}};
        end
        SZ_HALF: begin
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata = {(XLEN/16){i_store_data[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_store_data;
        end
      endcase
    end
  end

  always_comb begin
    w_shifted   = i_rdata >> {i_addr_lo, 3'b000};
    o_load_data = w_shifted;
    case (i_funct3)
      F3_B:    o_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit sitting behind the load/store queue.
// Accepts one op at a time, issues it on a valid/ready memory port, formats
// the response and returns a write-back packet on the CDB. Store-to-load
// forwarded results from the LSQ share the CDB port without touching memory.
// Ports:
//   clk, rst (async active-low), flush
//   execute_pkt / alu_rdy         - op issue from the LSQ
//   cache_stall                   - memory op outstanding
//   dmem_req_* / dmem_resp_*      - data-memory port
//   forward_rdy/forward_pkt/forward_re - forwarded load results
//   cdb_pkt / cdb_gnt             - write-back port
// XLEN must match uarch_pkg::MAU_XLEN (packet field width).
module mem_access_unit
  import uarch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          FWD_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  instruction_t      execute_pkt,
  output logic              alu_rdy,
  output logic              cache_stall,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [XLEN-1:0]   dmem_req_wdata,
  output logic [3:0]        dmem_req_be,
  input  logic              dmem_resp_valid,
  input  logic [XLEN-1:0]   dmem_resp_rdata,
  input  logic              forward_rdy,
  input  writeback_packet_t forward_pkt,
  output logic              forward_re,
  output writeback_packet_t cdb_pkt,
  input  logic              cdb_gnt
);

  mau_state_e      r_state;
  mau_state_e      w_next;
  instruction_t    r_op;
  logic [XLEN-1:0] r_data;
  logic            r_exc;

  logic            w_accept;
  logic            w_mem_v;
  logic            w_fwd_v;
  logic            w_sel_fwd;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;

  mem_lane_fmt #(.XLEN(XLEN)) u_fmt (
    .i_is_store   (r_op.is_store),
    .i_funct3     (r_op.funct3),
    .i_addr_lo    (r_op.addr[1:0]),
    .i_store_data (r_op.store_data),
    .i_rdata      (dmem_resp_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op   <= '0;
      r_data <= '0;
      r_exc  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= execute_pkt;
      r_data <= '0;
      r_exc  <= is_misaligned(execute_pkt.funct3, execute_pkt.addr[1:0]);
    end else if (r_state == WAIT && dmem_resp_valid && !flush) begin
      r_data <= r_op.is_store ? '0 : w_load_data;
      r_exc  <= 1'b0;
    end
  end

  always_comb begin
    w_next         = r_state;
    alu_rdy        = (r_state == IDLE) & ~flush & rst;
    w_accept       = alu_rdy & execute_pkt.is_valid;
    cache_stall    = (r_state == REQ) | (r_state == WAIT) | (r_state == DRAIN);

    // A flushed request is withdrawn in the same cycle, so ready is ignored.
    dmem_req_valid = (r_state == REQ) & r_op.is_valid & ~flush;
    dmem_req_we    = dmem_req_valid & r_op.is_store;
    dmem_req_addr  = dmem_req_valid ? {r_op.addr[XLEN-1:2], 2'b00} : '0;
    dmem_req_wdata = dmem_req_valid ? w_wdata : '0;
    dmem_req_be    = dmem_req_valid ? w_be : '0;

    // CDB source select: forward wins ties when FWD_FIRST, else the memory
    // result goes first and the forward stays pending in the LSQ.
    w_mem_v        = (r_state == WB) & r_op.is_valid & ~flush;
    w_fwd_v        = forward_rdy & forward_pkt.valid & rst & ~flush;
    w_sel_fwd      = w_fwd_v & (FWD_FIRST | ~w_mem_v);
    forward_re     = w_sel_fwd & cdb_gnt;

    cdb_pkt        = '0;
    if (w_sel_fwd) begin
      cdb_pkt = forward_pkt;
    end else if (w_mem_v) begin
      cdb_pkt.valid     = 1'b1;
      cdb_pkt.dest_tag  = r_op.dest_tag;
      cdb_pkt.data      = r_data;
      cdb_pkt.exception = r_exc;
    end

    case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = is_misaligned(execute_pkt.funct3, execute_pkt.addr[1:0]) ? WB : REQ;
      end
      REQ: begin
        if (flush)               w_next = IDLE;
        else if (dmem_req_ready) w_next = WAIT;
      end
      WAIT: begin
        // Response coinciding with flush is consumed here; nothing left to drain.
        if (dmem_resp_valid) w_next = flush ? IDLE : WB;
        else if (flush)      w_next = DRAIN;
      end
      WB: begin
        if (flush)                        w_next = IDLE;
        else if (cdb_gnt && !w_sel_fwd)   w_next = IDLE;
      end
      DRAIN: begin
        if (dmem_resp_valid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import uarch_pkg::*;

  logic              clk;
  logic              rst;
  logic              flush;
  instruction_t      execute_pkt;
  logic              alu_rdy;
  logic              cache_stall;
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [31:0]       dmem_req_addr;
  logic [31:0]       dmem_req_wdata;
  logic [3:0]        dmem_req_be;
  logic              dmem_resp_valid;
  logic [31:0]       dmem_resp_rdata;
  logic              forward_rdy;
  writeback_packet_t forward_pkt;
  logic              forward_re;
  writeback_packet_t cdb_pkt;
  logic              cdb_gnt;

  mem_access_unit #(.XLEN(32), .FWD_FIRST(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .execute_pkt     (execute_pkt),
    .alu_rdy         (alu_rdy),
    .cache_stall     (cache_stall),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_be     (dmem_req_be),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_rdata (dmem_resp_rdata),
    .forward_rdy     (forward_rdy),
    .forward_pkt     (forward_pkt),
    .forward_re      (forward_re),
    .cdb_pkt         (cdb_pkt),
    .cdb_gnt         (cdb_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference expectations
  writeback_packet_t want_q[$];
  logic        want_req_ok = 1'b0;
  logic [31:0] want_addr   = '0;
  logic [31:0] want_wdata  = '0;
  logic [3:0]  want_be     = '0;
  logic        want_we     = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Access size in bytes from funct3
  function automatic int unsigned m_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] w;
    logic [31:0] v;
    w = rd >> ((a % 4) * 8);
    case (f3)
      3'd0: begin v = w % 256;   return (v >= 128)   ? v - 32'd256   : v; end
      3'd1: begin v = w % 65536; return (v >= 32768) ? v - 32'd65536 : v; end
      3'd4: return w % 256;
      3'd5: return w % 65536;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3,
                                      input logic [31:0] a);
    int unsigned n;
    if (!st) return 4'h0;
    n = m_size(f3);
    return 4'(((32'd1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic st, input logic [2:0] f3,
                                          input logic [31:0] d);
    if (!st) return '0;
    case (m_size(f3))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Per-cycle compare against the reference
  always @(negedge clk) begin
    if (rst) begin
      if (dmem_req_valid) begin
        chk("req_allowed", 64'(want_req_ok), 64'd1);
        chk("req_addr", 64'(dmem_req_addr), 64'(want_addr));
        chk("req_be", 64'(dmem_req_be), 64'(want_be));
        chk("req_wdata", 64'(dmem_req_wdata), 64'(want_wdata));
        chk("req_we", 64'(dmem_req_we), 64'(want_we));
      end
      if (cdb_pkt.valid) begin
        if (want_q.size() == 0) begin
          chk("cdb_unexpected", 64'(cdb_pkt.valid), 64'd0);
        end else begin
          chk("cdb_pkt", 64'(cdb_pkt), 64'(want_q[0]));
          if (cdb_gnt) void'(want_q.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [5:0] tag);
    execute_pkt.is_valid   = 1'b1;
    execute_pkt.is_store   = st;
    execute_pkt.funct3     = f3;
    execute_pkt.addr       = a;
    execute_pkt.store_data = sd;
    execute_pkt.dest_tag   = tag;
    tick();
    execute_pkt = '0;
  endtask

  task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
    want_addr   = a & 32'hFFFF_FFFC;
    want_be     = m_be(st, f3, a);
    want_wdata  = m_wdata(st, f3, sd);
    want_we     = st;
    want_req_ok = !m_mis(f3, a);
  endtask

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input logic [5:0] tag,
                        input int rdy_dly, input int resp_dly, input logic [3:0] lit_be,
                        input logic [31:0] lit_wdata, input logic [31:0] lit_data);
    writeback_packet_t e;
    logic mis;
    mis         = m_mis(f3, a);
    e.valid     = 1'b1;
    e.dest_tag  = tag;
    e.exception = mis;
    e.data      = (mis || st) ? 32'd0 : m_load(f3, a, rd);
    want_q.push_back(e);
    set_req(st, f3, a, sd);
    chk("alu_rdy_idle", 64'(alu_rdy), 64'd1);
    issue(st, f3, a, sd, tag);
    if (mis) begin
      chk("mis_no_req", 64'(dmem_req_valid), 64'd0);
      chk("mis_stall", 64'(cache_stall), 64'd0);
      chk("mis_exc", 64'(cdb_pkt.exception), 64'd1);
      chk("mis_data", 64'(cdb_pkt.data), 64'(lit_data));
      cdb_gnt = 1'b1;
      tick();
      cdb_gnt = 1'b0;
    end else begin
      chk("lit_be", 64'(dmem_req_be), 64'(lit_be));
      chk("lit_wdata", 64'(dmem_req_wdata), 64'(lit_wdata));
      for (int k = 0; k <= rdy_dly; k++) begin
        chk("req_valid_held", 64'(dmem_req_valid), 64'd1);
        chk("stall_req", 64'(cache_stall), 64'd1);
        if (k == rdy_dly) dmem_req_ready = 1'b1;
        tick();
      end
      dmem_req_ready = 1'b0;
      want_req_ok    = 1'b0;
      for (int k = 0; k < resp_dly; k++) begin
        chk("wait_no_req", 64'(dmem_req_valid), 64'd0);
        tick();
      end
      chk("wait_stall", 64'(cache_stall), 64'd1);
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = rd;
      tick();
      dmem_resp_valid = 1'b0;
      chk("wb_valid", 64'(cdb_pkt.valid), 64'd1);
      chk("wb_tag", 64'(cdb_pkt.dest_tag), 64'(tag));
      chk("lit_data", 64'(cdb_pkt.data), 64'(lit_data));
      cdb_gnt = 1'b1;
      tick();
      cdb_gnt = 1'b0;
    end
    chk("back_idle", 64'(alu_rdy), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    writeback_packet_t ef;
    writeback_packet_t el;
    rst = 1'b0; flush = 1'b0; execute_pkt = '0; dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0; dmem_resp_rdata = '0; forward_rdy = 1'b0;
    forward_pkt = '0; cdb_gnt = 1'b0;
    #1;
    chk("rst_alu_rdy", 64'(alu_rdy), 64'd0);
    chk("rst_stall", 64'(cache_stall), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_cdb", 64'(cdb_pkt), 64'd0);
    chk("rst_fwd_re", 64'(forward_re), 64'd0);
    tick(); tick();
    rst = 1'b1;
    #1;

    //     st  f3    addr          sdata         rdata         tag rdy resp be    wdata         data
    run_op(0, 3'd0, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 5, 0, 0, 4'h0, 32'h0,        32'hFFFF_FF80);
    run_op(1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        6, 3, 1, 4'hC, 32'hABCD_ABCD, 32'h0);
    run_op(0, 3'd2, 32'h0000_3001, 32'h0,        32'h0,         8, 0, 0, 4'h0, 32'h0,        32'h0);
    run_op(1, 3'd0, 32'h0000_1001, 32'h0000_00A5, 32'h0,       10, 0, 0, 4'h2, 32'hA5A5_A5A5, 32'h0);
    run_op(0, 3'd1, 32'h0000_0002, 32'h0,        32'h8001_0000, 11, 1, 2, 4'h0, 32'h0,        32'hFFFF_8001);
    run_op(0, 3'd5, 32'h0000_0002, 32'h0,        32'h8001_0000, 12, 0, 0, 4'h0, 32'h0,        32'h0000_8001);
    run_op(0, 3'd4, 32'h0000_0001, 32'h0,        32'h0000_F000, 13, 0, 0, 4'h0, 32'h0,        32'h0000_00F0);
    run_op(1, 3'd2, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,       14, 2, 0, 4'hF, 32'hDEAD_BEEF, 32'h0);
    run_op(1, 3'd1, 32'h0000_2001, 32'h1111_2222, 32'h0,       15, 0, 0, 4'h0, 32'h0,        32'h0);
    run_op(0, 3'd7, 32'h0000_0008, 32'h0,        32'h89AB_CDEF, 16, 0, 0, 4'h0, 32'h0,        32'h89AB_CDEF);

    // Flush in WAIT, response two cycles later is drained
    set_req(0, 3'd2, 32'h0000_4000, 32'h0);
    issue(0, 3'd2, 32'h0000_4000, 32'h0, 6'd7);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    want_req_ok = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_wait_alu_rdy", 64'(alu_rdy), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("drain_alu_rdy", 64'(alu_rdy), 64'd0);
    chk("drain_stall", 64'(cache_stall), 64'd1);
    chk("drain_no_cdb", 64'(cdb_pkt.valid), 64'd0);
    tick();
    chk("drain_alu_rdy2", 64'(alu_rdy), 64'd0);
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'h5555_5555;
    tick();
    dmem_resp_valid = 1'b0;
    chk("post_drain_alu_rdy", 64'(alu_rdy), 64'd1);
    chk("post_drain_no_cdb", 64'(cdb_pkt.valid), 64'd0);
    chk("post_drain_stall", 64'(cache_stall), 64'd0);

    // Flush in REQ with ready high: request must not be issued
    set_req(1, 3'd2, 32'h0000_7000, 32'h1);
    issue(1, 3'd2, 32'h0000_7000, 32'h1, 6'd17);
    want_req_ok = 1'b0;
    flush = 1'b1;
    dmem_req_ready = 1'b1;
    #1;
    chk("flush_req_valid", 64'(dmem_req_valid), 64'd0);
    tick();
    flush = 1'b0;
    dmem_req_ready = 1'b0;
    #1;
    chk("flush_req_idle", 64'(alu_rdy), 64'd1);
    chk("flush_req_stall", 64'(cache_stall), 64'd0);

    // Forward only, unit idle
    forward_pkt = '{valid: 1'b1, dest_tag: 6'd3, data: 32'hDEAD_0001, exception: 1'b0};
    want_q.push_back(forward_pkt);
    forward_rdy = 1'b1;
    cdb_gnt = 1'b1;
    #1;
    chk("fwd_idle_re", 64'(forward_re), 64'd1);
    chk("fwd_idle_data", 64'(cdb_pkt.data), 64'hDEAD_0001);
    tick();
    forward_rdy = 1'b0;
    cdb_gnt = 1'b0;
    #1;
    chk("fwd_idle_state", 64'(alu_rdy), 64'd1);
    chk("fwd_idle_stall", 64'(cache_stall), 64'd0);

    // Flush blocks the forward pop
    forward_rdy = 1'b1;
    flush = 1'b1;
    cdb_gnt = 1'b1;
    #1;
    chk("fwd_flush_re", 64'(forward_re), 64'd0);
    chk("fwd_flush_cdb", 64'(cdb_pkt.valid), 64'd0);
    tick();
    forward_rdy = 1'b0;
    flush = 1'b0;
    cdb_gnt = 1'b0;
    #1;

    // Forward and WB load together: forward first, then load
    ef = '{valid: 1'b1, dest_tag: 6'd12, data: 32'hCAFE_BABE, exception: 1'b0};
    el = '{valid: 1'b1, dest_tag: 6'd9, data: m_load(3'd2, 32'h0000_5000, 32'h1122_3344), exception: 1'b0};
    want_q.push_back(ef);
    want_q.push_back(el);
    set_req(0, 3'd2, 32'h0000_5000, 32'h0);
    issue(0, 3'd2, 32'h0000_5000, 32'h0, 6'd9);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    want_req_ok = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'h1122_3344;
    tick();
    dmem_resp_valid = 1'b0;
    forward_pkt = ef;
    forward_rdy = 1'b1;
    cdb_gnt = 1'b1;
    #1;
    chk("both_fwd_re", 64'(forward_re), 64'd1);
    chk("both_fwd_data", 64'(cdb_pkt.data), 64'hCAFE_BABE);
    tick();
    forward_rdy = 1'b0;
    #1;
    chk("both_load_re", 64'(forward_re), 64'd0);
    chk("both_load_data", 64'(cdb_pkt.data), 64'h1122_3344);
    chk("both_load_tag", 64'(cdb_pkt.dest_tag), 64'd9);
    tick();
    cdb_gnt = 1'b0;
    #1;
    chk("both_idle", 64'(alu_rdy), 64'd1);

    // Async reset in WAIT
    set_req(0, 3'd2, 32'h0000_6000, 32'h0);
    issue(0, 3'd2, 32'h0000_6000, 32'h0, 6'd20);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    want_req_ok = 1'b0;
    #2;
    rst = 1'b0;
    forward_pkt = ef;
    forward_rdy = 1'b1;
    cdb_gnt = 1'b1;
    #1;
    chk("arst_alu_rdy", 64'(alu_rdy), 64'd0);
    chk("arst_stall", 64'(cache_stall), 64'd0);
    chk("arst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("arst_cdb", 64'(cdb_pkt), 64'd0);
    chk("arst_fwd_re", 64'(forward_re), 64'd0);
    forward_rdy = 1'b0;
    cdb_gnt = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_rel_alu_rdy", 64'(alu_rdy), 64'd1);
    chk("arst_rel_stall", 64'(cache_stall), 64'd0);

    run_op(0, 3'd2, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 21, 0, 0, 4'h0, 32'h0, 32'h0BAD_F00D);

    tick();
    chk("want_q_drained", 64'(want_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
